flash_region_loader: RTL and testbench

//  Sequences up to REGIONS boot-time copies from SPI NOR flash (via chameleon_spi_flash) into on-chip cart/ROM BRAM.

---
 rtl/loader_pkg.sv | 25 ++
 rtl/toggle_byte_capture.sv | 76 +++++++
 rtl/flash_region_loader.sv | 235 +++++++++++++++++++++++
 tb/tb_flash_region_loader.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and helpers for the flash region loader.
// Holds the sequencer state encoding and the helper used to slice the
// flattened per-region configuration buses.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    WAIT_BUSY,
    RUN,
    CHECK,
    DONE
  } state_e;

  localparam int MAX_REGIONS = 8;
  // Wide enough to hold MAX_REGIONS itself, which marks "past the last region".
  localparam int IDX_W = $clog2(MAX_REGIONS + 1);

  // Low bit of a region's field inside a flattened {region N-1 .. region 0} bus.
  function automatic int slice_lo(input int region, input int width);
    return region * width;
  endfunction

endpackage

// File: rtl/toggle_byte_capture.sv
// Byte capture for the toggle handshake of the SPI flash loader.
// A change of fl_req against its registered copy marks a new byte; the byte
// is written one clock later and fl_ack follows fl_req. Bytes outside the
// accept window are still acknowledged, but no write happens and they are
// not counted.
module toggle_byte_capture #(
  parameter int A_BITS   = 14,
  parameter int LEN_BITS = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                fl_req_i,
  input  logic [A_BITS-1:0]   fl_a_i,
  input  logic [7:0]          fl_q_i,
  input  logic                accept_i,
  input  logic                clr_cnt_i,
  output logic                toggle_o,
  output logic                fl_ack_o,
  output logic                wr_strobe_o,
  output logic [A_BITS-1:0]   wr_addr_o,
  output logic [7:0]          wr_data_o,
  output logic [LEN_BITS:0]   byte_cnt_o
);

  logic                req_q, req_d;
  logic                strobe_q, strobe_d;
  logic [A_BITS-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic [LEN_BITS:0]   cnt_q, cnt_d;

  assign toggle_o = (fl_req_i != req_q);

  // Next-state for the capture registers.
  always_comb begin
    req_d    = fl_req_i;
    strobe_d = toggle_o && accept_i;
    addr_d   = addr_q;
    data_d   = data_q;
    cnt_d    = cnt_q;
    if (toggle_o && accept_i) begin
      addr_d = fl_a_i;
      data_d = fl_q_i;
    end
    // Counting on the detect edge lets a byte that lands as busy falls
    // already show up in the count on the following CHECK cycle.
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (toggle_o && accept_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Capture registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      req_q    <= 1'b0;
      strobe_q <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      req_q    <= req_d;
      strobe_q <= strobe_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign fl_ack_o    = req_q;
  assign wr_strobe_o = strobe_q;
  assign wr_addr_o   = addr_q;
  assign wr_data_o   = data_q;
  assign byte_cnt_o  = cnt_q;

endmodule

// File: rtl/flash_region_loader.sv
// Boot-time sequencer copying up to REGIONS flash regions into cart/ROM BRAM.
// done_o holds the machine in reset until every enabled region is processed.
// Optional LOADER_TIMEOUT_EN: per-region watchdog over WAIT_BUSY+RUN that flags
// the region and forces CHECK after TIMEOUT_CYCLES.
//
// state     | meaning
// IDLE      | after reset, waiting for slot_valid
// SELECT    | pick region idx; skip disabled / zero-length, or finish
// START     | one-cycle start pulse to the flash loader
// WAIT_BUSY | waiting for the flash loader to raise busy
// RUN       | bytes streaming in; waiting for busy to drop
// CHECK     | compare byte count with length, advance to next region
// DONE      | all regions processed; reload restarts the sequence
module flash_region_loader
  import loader_pkg::*;
#(
  parameter int REGIONS  = 4,
  parameter int A_BITS   = 14,
  parameter int LEN_BITS = 16,
  parameter int OFS_BITS = 24
`ifdef LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1 << 22
`endif
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         slot_valid_i,
  input  logic                         reload_i,
  input  logic [REGIONS-1:0]           region_en_i,
  input  logic [REGIONS*A_BITS-1:0]    region_dest_i,
  input  logic [REGIONS*OFS_BITS-1:0]  region_ofs_i,
  input  logic [REGIONS*LEN_BITS-1:0]  region_len_i,
  output logic                         fl_start_o,
  output logic [A_BITS-1:0]            fl_start_addr_o,
  output logic [OFS_BITS-1:0]          fl_offset_o,
  output logic [LEN_BITS-1:0]          fl_amount_o,
  input  logic                         fl_busy_i,
  input  logic                         fl_req_i,
  input  logic [A_BITS-1:0]            fl_a_i,
  input  logic [7:0]                   fl_q_i,
  output logic                         fl_ack_o,
  output logic                         wr_strobe_o,
  output logic [A_BITS-1:0]            wr_addr_o,
  output logic [7:0]                   wr_data_o,
  output logic [2:0]                   cur_region_o,
  output logic                         done_o,
  output logic [REGIONS-1:0]           error_o
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [A_BITS-1:0]    dest_q, dest_d;
  logic [OFS_BITS-1:0]  ofs_q, ofs_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [REGIONS-1:0]   err_q, err_d;

  logic                 sel_en;
  logic [A_BITS-1:0]    sel_dest;
  logic [OFS_BITS-1:0]  sel_ofs;
  logic [LEN_BITS-1:0]  sel_len;
  logic [REGIONS-1:0]   cur_bit;

  logic                 toggle;
  logic                 accept;
  logic                 clr_cnt;
  logic                 dropping;
  logic [LEN_BITS:0]    byte_cnt;

`ifdef LOADER_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            drop_q, drop_d;
  assign dropping = drop_q;
`else
  assign dropping = 1'b0;
`endif

  assign accept = ((state_q == WAIT_BUSY) || (state_q == RUN)) && !dropping;

  // Region table lookup for the current index; cur_bit is empty past the end.
  always_comb begin
    sel_en   = 1'b0;
    sel_dest = '0;
    sel_ofs  = '0;
    sel_len  = '0;
    cur_bit  = '0;
    for (int r = 0; r < REGIONS; r++) begin
      if (idx_q == IDX_W'(r)) begin
        sel_en     = region_en_i[r];
        sel_dest   = region_dest_i[slice_lo(r, A_BITS) +: A_BITS];
        sel_ofs    = region_ofs_i[slice_lo(r, OFS_BITS) +: OFS_BITS];
        sel_len    = region_len_i[slice_lo(r, LEN_BITS) +: LEN_BITS];
        cur_bit[r] = 1'b1;
      end
    end
  end

  // Sequencer next-state, region latch and error flag updates.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dest_d  = dest_q;
    ofs_d   = ofs_q;
    len_d   = len_q;
    err_d   = err_q;
    clr_cnt = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    wd_d    = wd_q;
    drop_d  = drop_q;
`endif
    case (state_q)
      IDLE: begin
        if (slot_valid_i) state_d = SELECT;
      end
      SELECT: begin
        if (idx_q >= IDX_W'(REGIONS)) begin
          state_d = DONE;
        end else if (!sel_en || (sel_len == '0)) begin
          idx_d = idx_q + 1'b1;
        end else begin
          // Latched here so the flash loader sees stable values START..CHECK.
          dest_d  = sel_dest;
          ofs_d   = sel_ofs;
          len_d   = sel_len;
          state_d = START;
        end
      end
      START: begin
        clr_cnt = 1'b1;
        state_d = WAIT_BUSY;
`ifdef LOADER_TIMEOUT_EN
        wd_d    = WD_W'(TIMEOUT_CYCLES - 1);
        drop_d  = 1'b0;
`endif
      end
      WAIT_BUSY: begin
        if (fl_busy_i) state_d = RUN;
      end
      RUN: begin
        if (!fl_busy_i) state_d = CHECK;
      end
      CHECK: begin
        // A timed-out region is already flagged; its partial count is meaningless.
        if (!dropping && (byte_cnt != {1'b0, len_q})) err_d = err_d | cur_bit;
        idx_d   = idx_q + 1'b1;
        state_d = SELECT;
      end
      DONE: begin
        if (reload_i) begin
          idx_d   = '0;
          err_d   = '0;
          clr_cnt = 1'b1;
          state_d = SELECT;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef LOADER_TIMEOUT_EN
    if (((state_q == WAIT_BUSY) || (state_q == RUN)) && !drop_q) begin
      if (wd_q == '0) begin
        err_d   = err_d | cur_bit;
        drop_d  = 1'b1;
        state_d = CHECK;
      end else begin
        wd_d = wd_q - 1'b1;
      end
    end
`endif

    // Bytes arriving when no transfer is open are a loader protocol fault.
    if (toggle && !accept && !dropping) err_d = err_d | cur_bit;
  end

  // Sequencer state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dest_q  <= '0;
      ofs_q   <= '0;
      len_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dest_q  <= dest_d;
      ofs_q   <= ofs_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  // Watchdog down-counter and drop flag for the timed-out region.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wd_q   <= '0;
      drop_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      drop_q <= drop_d;
    end
  end
`endif

  toggle_byte_capture #(
    .A_BITS   (A_BITS),
    .LEN_BITS (LEN_BITS)
  ) u_capture (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .fl_req_i    (fl_req_i),
    .fl_a_i      (fl_a_i),
    .fl_q_i      (fl_q_i),
    .accept_i    (accept),
    .clr_cnt_i   (clr_cnt),
    .toggle_o    (toggle),
    .fl_ack_o    (fl_ack_o),
    .wr_strobe_o (wr_strobe_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .byte_cnt_o  (byte_cnt)
  );

  assign fl_start_o      = (state_q == START);
  assign fl_start_addr_o = dest_q;
  assign fl_offset_o     = ofs_q;
  assign fl_amount_o     = len_q;
  assign cur_region_o    = idx_q[2:0];
  assign done_o          = (state_q == DONE);
  assign error_o         = err_q;

endmodule

// File: tb/tb_flash_region_loader.sv
// Bench for flash_region_loader: emulates the SPI flash loader side, queues the
// expected start requests and BRAM writes, and checks them from a monitor.
`timescale 1ns/1ps
module tb_flash_region_loader;

  localparam int REGIONS  = 4;
  localparam int A_BITS   = 14;
  localparam int LEN_BITS = 16;
  localparam int OFS_BITS = 24;

  logic                         clk = 1'b0;
  logic                         reset_i = 1'b1;
  logic                         slot_valid_i = 1'b0;
  logic                         reload_i = 1'b0;
  logic [REGIONS-1:0]           region_en_i = '0;
  logic [REGIONS*A_BITS-1:0]    region_dest_i = '0;
  logic [REGIONS*OFS_BITS-1:0]  region_ofs_i = '0;
  logic [REGIONS*LEN_BITS-1:0]  region_len_i = '0;
  logic                         fl_start_o;
  logic [A_BITS-1:0]            fl_start_addr_o;
  logic [OFS_BITS-1:0]          fl_offset_o;
  logic [LEN_BITS-1:0]          fl_amount_o;
  logic                         fl_busy_i = 1'b0;
  logic                         fl_req_i = 1'b0;
  logic [A_BITS-1:0]            fl_a_i = '0;
  logic [7:0]                   fl_q_i = '0;
  logic                         fl_ack_o;
  logic                         wr_strobe_o;
  logic [A_BITS-1:0]            wr_addr_o;
  logic [7:0]                   wr_data_o;
  logic [2:0]                   cur_region_o;
  logic                         done_o;
  logic [REGIONS-1:0]           error_o;

  flash_region_loader #(
    .REGIONS  (REGIONS),
    .A_BITS   (A_BITS),
    .LEN_BITS (LEN_BITS),
    .OFS_BITS (OFS_BITS)
`ifdef LOADER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (64)
`endif
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .slot_valid_i    (slot_valid_i),
    .reload_i        (reload_i),
    .region_en_i     (region_en_i),
    .region_dest_i   (region_dest_i),
    .region_ofs_i    (region_ofs_i),
    .region_len_i    (region_len_i),
    .fl_start_o      (fl_start_o),
    .fl_start_addr_o (fl_start_addr_o),
    .fl_offset_o     (fl_offset_o),
    .fl_amount_o     (fl_amount_o),
    .fl_busy_i       (fl_busy_i),
    .fl_req_i        (fl_req_i),
    .fl_a_i          (fl_a_i),
    .fl_q_i          (fl_q_i),
    .fl_ack_o        (fl_ack_o),
    .wr_strobe_o     (wr_strobe_o),
    .wr_addr_o       (wr_addr_o),
    .wr_data_o       (wr_data_o),
    .cur_region_o    (cur_region_o),
    .done_o          (done_o),
    .error_o         (error_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int starts_seen = 0;
  int starts_used = 0;

  logic [63:0] exp_wr[$];
  logic [63:0] exp_start[$];
  logic [REGIONS-1:0] exp_err;

  // Region plan: mode 0 = normal, 1 = last byte coincides with busy fall, 2 = busy stuck.
  bit                 cfg_en[REGIONS];
  int                 cfg_len[REGIONS];
  int                 cfg_nb[REGIONS];
  int                 cfg_mode[REGIONS];
  logic [A_BITS-1:0]  cfg_dest[REGIONS];
  logic [OFS_BITS-1:0] cfg_ofs[REGIONS];
  bit                 noise;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares every write and every start pulse against the queues.
  always @(negedge clk) begin
    logic [63:0] e;
    if (wr_strobe_o) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write", {50'd0, wr_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_wr.pop_front();
        check("write", {42'd0, wr_addr_o, wr_data_o}, e);
      end
    end
    if (fl_start_o) begin
      starts_seen++;
      if (exp_start.size() == 0) begin
        check("unexpected_start", {61'd0, cur_region_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_start.pop_front();
        check("start", {7'd0, cur_region_o, fl_start_addr_o, fl_offset_o, fl_amount_o}, e);
      end
    end
  end

  task automatic apply_cfg();
    for (int r = 0; r < REGIONS; r++) begin
      region_en_i[r] = cfg_en[r];
      region_dest_i[r*A_BITS +: A_BITS]     = cfg_dest[r];
      region_ofs_i[r*OFS_BITS +: OFS_BITS]  = cfg_ofs[r];
      region_len_i[r*LEN_BITS +: LEN_BITS]  = LEN_BITS'(cfg_len[r]);
    end
  endtask

  // Reference model: which regions get started and which end flagged.
  task automatic plan_push();
    exp_err = '0;
    for (int r = 0; r < REGIONS; r++) begin
      if (cfg_en[r] && cfg_len[r] != 0) begin
        exp_start.push_back({7'd0, 3'(r), cfg_dest[r], cfg_ofs[r], LEN_BITS'(cfg_len[r])});
        if (cfg_mode[r] == 2 || cfg_nb[r] != cfg_len[r]) exp_err[r] = 1'b1;
      end
    end
  endtask

  task automatic clear_cfg();
    for (int r = 0; r < REGIONS; r++) begin
      cfg_en[r] = 1'b0; cfg_len[r] = 0; cfg_nb[r] = 0; cfg_mode[r] = 0;
      cfg_dest[r] = '0; cfg_ofs[r] = '0;
    end
    noise = 1'b0;
  endtask

  task automatic restart_reset();
    reset_i = 1'b1; slot_valid_i = 1'b0; fl_req_i = 1'b0; fl_busy_i = 1'b0; reload_i = 1'b0;
    tick(2);
    reset_i = 1'b0;
    apply_cfg();
    plan_push();
    slot_valid_i = 1'b1;
  endtask

  task automatic restart_reload();
    apply_cfg();
    plan_push();
    reload_i = 1'b1;
    tick(1);
    reload_i = 1'b0;
    check("reload_done_clear", {63'd0, done_o}, 64'd0);
    check("reload_err_clear", {60'd0, error_o}, 64'd0);
  endtask

  task automatic wait_start_or_done(output bit ok);
    int b = 0;
    while (starts_seen <= starts_used && !done_o && b < 400) begin
      tick(1);
      b++;
    end
    ok = (starts_seen > starts_used) || done_o;
  endtask

  task automatic send_byte(input int r, input int k, input bit last_with_busy_fall);
    logic [A_BITS-1:0] a;
    logic [7:0] q;
    a = cfg_dest[r] + A_BITS'(k);
    q = 8'($urandom);
    fl_a_i = a;
    fl_q_i = q;
    fl_req_i = ~fl_req_i;
    if (last_with_busy_fall) fl_busy_i = 1'b0;
    exp_wr.push_back({42'd0, a, q});
    tick(1);
    check("ack_echo", {63'd0, fl_ack_o}, {63'd0, fl_req_i});
  endtask

  // Flash loader emulator for one started region.
  task automatic serve(input int r);
    int b = 0;
    while (starts_seen <= starts_used && b < 200) begin
      tick(1);
      b++;
    end
    if (starts_seen <= starts_used) begin
      check("start_seen", 64'd0, 64'd1);
      return;
    end
    starts_used++;
    tick($urandom_range(0, 3));
    fl_busy_i = 1'b1;
    if (noise) begin
      reload_i = 1'b1; slot_valid_i = 1'b0;
      tick(1);
      reload_i = 1'b0;
    end
    if (cfg_mode[r] == 2) begin
      bit ok;
      tick(50);
      check("no_early_timeout", {63'd0, error_o[r]}, 64'd0);
      wait_start_or_done(ok);
      check("timeout_advance", {63'd0, ok}, 64'd1);
      fl_busy_i = 1'b0;
      return;
    end
    tick($urandom_range(1, 2));
    for (int k = 0; k < cfg_nb[r]; k++) begin
      send_byte(r, k, (cfg_mode[r] == 1) && (k == cfg_nb[r] - 1));
      if (k != cfg_nb[r] - 1) tick($urandom_range(1, 2));
    end
    if (cfg_mode[r] != 1) begin
      tick($urandom_range(1, 3));
      fl_busy_i = 1'b0;
    end
  endtask

  task automatic serve_all();
    for (int r = 0; r < REGIONS; r++) begin
      if (cfg_en[r] && cfg_len[r] != 0) serve(r);
    end
  endtask

  task automatic wait_done(input string tag);
    int b = 0;
    while (!done_o && b < 3000) begin
      tick(1);
      b++;
    end
    check({tag, "_done"}, {63'd0, done_o}, 64'd1);
    check({tag, "_error"}, {60'd0, error_o}, {60'd0, exp_err});
    check({tag, "_writes_left"}, 64'(exp_wr.size()), 64'd0);
    check({tag, "_starts_left"}, 64'(exp_start.size()), 64'd0);
    exp_wr.delete();
    exp_start.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    clear_cfg();
    tick(3);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_error", {60'd0, error_o}, 64'd0);
    check("rst_ack", {63'd0, fl_ack_o}, 64'd0);
    check("rst_strobe", {63'd0, wr_strobe_o}, 64'd0);
    check("rst_start", {63'd0, fl_start_o}, 64'd0);

    // Single region, four bytes at BRAM address 0..3.
    cfg_en[0] = 1'b1; cfg_len[0] = 4; cfg_nb[0] = 4;
    restart_reset();
    serve_all();
    wait_done("single");

    // Regions 0 and 2 enabled, region 1 disabled and zero length.
    clear_cfg();
    cfg_en[0] = 1'b1; cfg_len[0] = 8;  cfg_nb[0] = 8;  cfg_dest[0] = 14'h0100; cfg_ofs[0] = 24'h010000;
    cfg_en[1] = 1'b0; cfg_len[1] = 0;
    cfg_en[2] = 1'b1; cfg_len[2] = 16; cfg_nb[2] = 16; cfg_dest[2] = 14'h2000; cfg_ofs[2] = 24'h123456;
    restart_reload();
    serve_all();
    wait_done("skip");

    // Short transfer flags region 0; region 1 is still loaded.
    clear_cfg();
    cfg_en[0] = 1'b1; cfg_len[0] = 8; cfg_nb[0] = 7; cfg_dest[0] = 14'h0040;
    cfg_en[1] = 1'b1; cfg_len[1] = 5; cfg_nb[1] = 5; cfg_dest[1] = 14'h3FFE;
    restart_reset();
    serve_all();
    wait_done("short");

    // Reset in the middle of a transfer, then a clean reload from IDLE.
    clear_cfg();
    cfg_en[0] = 1'b1; cfg_len[0] = 8; cfg_nb[0] = 8; cfg_dest[0] = 14'h0800;
    restart_reset();
    begin
      bit ok;
      wait_start_or_done(ok);
      check("mid_start", {63'd0, ok}, 64'd1);
      starts_used = starts_seen;
      fl_busy_i = 1'b1;
      tick(2);
      for (int k = 0; k < 3; k++) begin
        send_byte(0, k, 1'b0);
        tick(1);
      end
    end
    reset_i = 1'b1; fl_req_i = 1'b0; fl_busy_i = 1'b0;
    tick(1);
    check("mid_rst_strobe", {63'd0, wr_strobe_o}, 64'd0);
    check("mid_rst_ack", {63'd0, fl_ack_o}, 64'd0);
    check("mid_rst_addr", {50'd0, fl_start_addr_o}, 64'd0);
    check("mid_rst_amount", {48'd0, fl_amount_o}, 64'd0);
    check("mid_rst_wraddr", {50'd0, wr_addr_o}, 64'd0);
    check("mid_rst_region", {61'd0, cur_region_o}, 64'd0);
    exp_start.delete();
    plan_push();
    reset_i = 1'b0;
    serve_all();
    wait_done("mid_reset");

    // Last byte arrives in the same cycle busy falls.
    clear_cfg();
    cfg_en[0] = 1'b1; cfg_len[0] = 6; cfg_nb[0] = 6; cfg_mode[0] = 1; cfg_dest[0] = 14'h1230;
    restart_reload();
    serve_all();
    wait_done("coincident");

`ifdef LOADER_TIMEOUT_EN
    // Busy stuck high: watchdog flags region 0, region 1 still loads.
    clear_cfg();
    cfg_en[0] = 1'b1; cfg_len[0] = 4; cfg_nb[0] = 0; cfg_mode[0] = 2;
    cfg_en[1] = 1'b1; cfg_len[1] = 3; cfg_nb[1] = 3; cfg_dest[1] = 14'h0200;
    restart_reset();
    serve_all();
    wait_done("timeout");
`endif

    // Random region tables, byte counts and ignored reload/slot_valid noise.
    for (int t = 0; t < 8; t++) begin
      int k;
      clear_cfg();
      for (int r = 0; r < REGIONS; r++) begin
        cfg_en[r]   = 1'($urandom_range(0, 1));
        cfg_len[r]  = $urandom_range(0, 5);
        cfg_dest[r] = A_BITS'($urandom);
        cfg_ofs[r]  = OFS_BITS'($urandom);
        cfg_nb[r]   = cfg_len[r];
        k = $urandom_range(0, 3);
        if (k == 0) cfg_nb[r] = cfg_len[r] + 1;
        else if (k == 1 && cfg_len[r] > 0) cfg_nb[r] = cfg_len[r] - 1;
        cfg_mode[r] = (cfg_nb[r] > 0 && $urandom_range(0, 1) == 1) ? 1 : 0;
      end
      noise = 1'($urandom_range(0, 1));
      if (t % 2 == 0) restart_reset();
      else restart_reload();
      serve_all();
      wait_done("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
